router_fifo: RTL

- Per-destination output FIFO of the 1x3 router.
- Sits directly downstream of the register stage. Captures its byte stream (`dout`) plus the `lfd_state` header marker.
- Buffers up to DEPTH entries and presents bytes to the destination port on `read_enb`.
- Tracks packet length from the stored header so that `data_out` returns to 0 once the parity byte has been delivered.

---
 rtl/router_pkg.sv | 28 ++
 rtl/router_fifo_mem.sv | 57 +++++
 rtl/router_fifo.sv | 113 +++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared constants and types for the 1x3 router datapath.
// Header byte layout: [1:0] destination port, [7:2] payload length.
package router_pkg;

    localparam int FIFO_DEPTH  = 16;
    localparam int DATA_W      = 8;

    localparam int DEST_LSB    = 0;
    localparam int DEST_MSB    = 1;
    localparam int LEN_LSB     = 2;
    localparam int LEN_MSB     = 7;
    localparam int MAX_PAYLOAD = 63;

    localparam int LEN_W       = LEN_MSB - LEN_LSB + 1;
    localparam int PKT_CNT_W   = LEN_W + 1;

    // One stored FIFO entry: header marker plus the byte itself.
    typedef struct packed {
        logic              lfd;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

    // Bytes still to be delivered after a header: payload plus parity.
    function automatic logic [PKT_CNT_W-1:0] pkt_remaining(input logic [LEN_W-1:0] len);
        return {1'b0, len} + PKT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Storage array for router_fifo: DEPTH x {lfd, byte}.
// Synchronous write port, registered read port with a clear/zero path,
// and a combinational peek of the head entry's header fields.
module router_fifo_mem
    import router_pkg::*;
#(
    parameter int DEPTH  = router_pkg::FIFO_DEPTH,
    parameter int DATA_W = router_pkg::DATA_W,
    parameter int ADDR_W = 4
) (
    input  logic                 clock,
    input  logic                 clr_i,
    input  logic                 we_i,
    input  logic [ADDR_W-1:0]    waddr_i,
    input  logic [DATA_W:0]      wdata_i,
    input  logic                 re_i,
    input  logic                 zero_i,
    input  logic [ADDR_W-1:0]    raddr_i,
    output logic [DATA_W-1:0]    rdata_o,
    output logic                 head_lfd_o,
    output logic [LEN_W-1:0]     head_len_o
);

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  lfd_q;
    logic [DATA_W-1:0] rdata_q;

    // Byte storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (we_i) begin
            data_q[waddr_i] <= wdata_i[DATA_W-1:0];
        end
    end

    // Header markers are cleared on flush so stale entries never look like headers.
    always_ff @(posedge clock) begin
        if (clr_i) begin
            lfd_q <= '0;
        end else if (we_i) begin
            lfd_q[waddr_i] <= wdata_i[DATA_W];
        end
    end

    // Registered read port; forced to zero on flush or when the port goes idle.
    always_ff @(posedge clock) begin
        if (clr_i || zero_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= data_q[raddr_i];
        end
    end

    assign rdata_o    = rdata_q;
    assign head_lfd_o = lfd_q[raddr_i];
    assign head_len_o = data_q[raddr_i][LEN_MSB:LEN_LSB];

endmodule

// File: rtl/router_fifo.sv
// Per-destination output FIFO of the 1x3 router.
// Buffers {lfd, byte} entries from the register stage and tracks the packet
// length so data_out returns to zero once the parity byte has gone out.
// Optional build macro ROUTER_FIFO_OVF_EN adds a sticky overflow output.
module router_fifo
    import router_pkg::*;
#(
    parameter int DEPTH  = router_pkg::FIFO_DEPTH,
    parameter int DATA_W = router_pkg::DATA_W,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              read_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
`ifdef ROUTER_FIFO_OVF_EN
    output logic              overflow,
`endif
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] data_out
);

    logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

    logic               flush;
    logic               wr_fire;
    logic               rd_fire;
    logic               idle_zero;
    logic               head_lfd;
    logic [LEN_W-1:0]   head_len;

    assign flush = !resetn || soft_reset;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

    // Both requests are qualified against the flags before the edge.
    assign wr_fire   = write_enb && !full;
    assign rd_fire   = read_enb && !empty;
    assign idle_zero = !rd_fire && (pkt_cnt_q == '0);

    // Next-state for pointers and the remaining-bytes counter.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (head_lfd) begin
                pkt_cnt_d = pkt_remaining(head_len);
            end else if (pkt_cnt_q != '0) begin
                pkt_cnt_d = pkt_cnt_q - 1'b1;
            end
        end
    end

    // Control state; hard reset and soft flush both discard everything.
    always_ff @(posedge clock) begin
        if (flush) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pkt_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

`ifdef ROUTER_FIFO_OVF_EN
    logic ovf_q;

    // Sticky flag for any write attempted while full.
    always_ff @(posedge clock) begin
        if (flush) begin
            ovf_q <= 1'b0;
        end else if (write_enb && full) begin
            ovf_q <= 1'b1;
        end
    end

    assign overflow = ovf_q;
`endif

    router_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clock      (clock),
        .clr_i      (flush),
        .we_i       (wr_fire && !flush),
        .waddr_i    (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i    ({lfd_state, data_in}),
        .re_i       (rd_fire),
        .zero_i     (idle_zero),
        .raddr_i    (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o    (data_out),
        .head_lfd_o (head_lfd),
        .head_len_o (head_len)
    );

endmodule
